// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the RISC datapath: accepts one 16-bit instruction
// on the s/w handshake and steps the register file, operand, ALU and status strobes.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_WAIT, ST_DECODE, ST_WRITE_IMM, ST_GET_A, ST_GET_B, ST_EXEC, ST_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_UNDEF
  } kind_t;

  state_t      state, state_nxt;
  logic [15:0] ir, ir_nxt;

  logic        w_nxt, write_nxt, vsel_nxt, err_nxt;
  logic        loada_nxt, loadb_nxt, loadc_nxt, loads_nxt, asel_nxt;
  logic [2:0]  readnum_nxt, writenum_nxt;
  logic [1:0]  aluop_nxt, shift_nxt;

  function automatic kind_t classify(input logic [15:0] i);
    case (i[15:11])
      5'b11010: classify = K_MOVI;
      5'b11000: classify = K_MOVR;
      5'b10100: classify = K_ADD;
      5'b10101: classify = K_CMP;
      5'b10110: classify = K_AND;
      5'b10111: classify = K_MVN;
      default:  classify = K_UNDEF;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      ST_WAIT: begin
        if (s) begin
          ir_nxt    = instr;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (classify(ir))
          K_MOVI:              state_nxt = ST_WRITE_IMM;
          K_ADD, K_AND, K_CMP: state_nxt = ST_GET_A;
          K_MOVR, K_MVN:       state_nxt = ST_GET_B;
          default:             state_nxt = ST_WAIT;
        endcase
      end
      ST_WRITE_IMM: state_nxt = ST_WAIT;
      ST_GET_A:     state_nxt = ST_GET_B;
      ST_GET_B:     state_nxt = ST_EXEC;
      ST_EXEC:      state_nxt = (classify(ir) == K_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_nxt = ST_WAIT;
      default:      state_nxt = ST_WAIT;
    endcase
    if (reset) begin
      state_nxt = ST_WAIT;
      ir_nxt    = 16'h0000;
    end
  end

  // Outputs are decoded from the upcoming state/ir so they land registered
  // in the same cycle the state register reaches that state.
  always_comb begin
    w_nxt        = 1'b0;
    readnum_nxt  = 3'b000;
    writenum_nxt = 3'b000;
    write_nxt    = 1'b0;
    vsel_nxt     = 1'b0;
    loada_nxt    = 1'b0;
    loadb_nxt    = 1'b0;
    loadc_nxt    = 1'b0;
    loads_nxt    = 1'b0;
    asel_nxt     = 1'b0;
    aluop_nxt    = 2'b00;
    shift_nxt    = 2'b00;
    err_nxt      = 1'b0;
    case (state_nxt)
      ST_WAIT:   w_nxt = 1'b1;
      ST_DECODE: err_nxt = (classify(ir_nxt) == K_UNDEF);
      ST_WRITE_IMM: begin
        writenum_nxt = ir_nxt[10:8];
        vsel_nxt     = 1'b1;
        write_nxt    = 1'b1;
      end
      ST_GET_A: begin
        readnum_nxt = ir_nxt[10:8];
        loada_nxt   = 1'b1;
      end
      ST_GET_B: begin
        readnum_nxt = ir_nxt[2:0];
        loadb_nxt   = 1'b1;
        shift_nxt   = ir_nxt[4:3];
      end
      ST_EXEC: begin
        shift_nxt = ir_nxt[4:3];
        if (classify(ir_nxt) == K_MOVR) begin
          aluop_nxt = 2'b00;
          asel_nxt  = 1'b1;
        end else begin
          aluop_nxt = ir_nxt[12:11];
        end
        if (classify(ir_nxt) == K_CMP) loads_nxt = 1'b1;
        else                           loadc_nxt = 1'b1;
      end
      ST_WRITE_REG: begin
        writenum_nxt = ir_nxt[7:5];
        write_nxt    = 1'b1;
      end
      default: w_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    state    <= state_nxt;
    ir       <= ir_nxt;
    w        <= w_nxt;
    readnum  <= readnum_nxt;
    writenum <= writenum_nxt;
    write    <= write_nxt;
    vsel     <= vsel_nxt;
    loada    <= loada_nxt;
    loadb    <= loadb_nxt;
    loadc    <= loadc_nxt;
    loads    <= loads_nxt;
    asel     <= asel_nxt;
    ALUop    <= aluop_nxt;
    shift    <= shift_nxt;
    err      <= err_nxt;
  end

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction table, hand-written reset corners and
// random instructions checked cycle by cycle against a per-instruction schedule model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] instr;
  logic        w, write, vsel, loada, loadb, loadc, loads, asel, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  ALUop, shift;
  logic [15:0] sximm8;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .ALUop(ALUop), .shift(shift), .sximm8(sximm8), .err(err)
  );

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        err;
  } out_t;

  typedef struct {
    logic [15:0] instr;
    int          wret;
    int          nwrite;
    int          nloads;
  } vec_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t observe();
    out_t o;
    o.w = w; o.readnum = readnum; o.writenum = writenum; o.write = write;
    o.vsel = vsel; o.loada = loada; o.loadb = loadb; o.loadc = loadc;
    o.loads = loads; o.asel = asel; o.aluop = ALUop; o.shift = shift;
    o.sximm8 = sximm8; o.err = err;
    return o;
  endfunction

  function automatic out_t wait_vec(input logic [15:0] i);
    out_t o;
    o = '0;
    o.w = 1'b1;
    o.sximm8 = {{8{i[7]}}, i[7:0]};
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, expv);
    end
  endtask

  // Expected per-cycle outputs for cycles 1..N after acceptance, ending in WAIT.
  task automatic build(input logic [15:0] i);
    out_t b, o;
    logic [4:0] key;
    bit movi, movr, add, cmp, andi, mvn, undef;
    key   = i[15:11];
    movi  = (key == 5'b11010);
    movr  = (key == 5'b11000);
    add   = (key == 5'b10100);
    cmp   = (key == 5'b10101);
    andi  = (key == 5'b10110);
    mvn   = (key == 5'b10111);
    undef = !(movi || movr || add || cmp || andi || mvn);
    b = wait_vec(i);
    b.w = 1'b0;
    exp_q.delete();
    o = b; o.err = undef; exp_q.push_back(o);
    if (movi) begin
      o = b; o.write = 1'b1; o.writenum = i[10:8]; o.vsel = 1'b1; exp_q.push_back(o);
    end else if (!undef) begin
      if (add || cmp || andi) begin
        o = b; o.readnum = i[10:8]; o.loada = 1'b1; exp_q.push_back(o);
      end
      o = b; o.readnum = i[2:0]; o.loadb = 1'b1; o.shift = i[4:3]; exp_q.push_back(o);
      o = b; o.shift = i[4:3]; o.aluop = movr ? 2'b00 : i[12:11]; o.asel = movr;
      if (cmp) o.loads = 1'b1; else o.loadc = 1'b1;
      exp_q.push_back(o);
      if (!cmp) begin
        o = b; o.write = 1'b1; o.writenum = i[7:5]; exp_q.push_back(o);
      end
    end
    exp_q.push_back(wait_vec(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a sampled WAIT cycle, ends in the sampled WAIT cycle after completion.
  task automatic run_instr(input logic [15:0] i, output int wret, output int nwrite,
                           output int nloads);
    out_t o;
    build(i);
    s = 1'b1;
    instr = i;
    wret = 0; nwrite = 0; nloads = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      o = observe();
      chk($sformatf("i%h_c%0d", i, k + 1), o, exp_q[k]);
      if (o.w && wret == 0) wret = k + 1;
      nwrite += int'(o.write);
      nloads += int'(o.loads);
      if (k == exp_q.size() - 1) begin
        s = 1'b0;
        instr = 16'($urandom);
      end else begin
        s = 1'($urandom);
        instr = 16'($urandom);
      end
    end
  endtask

  vec_t tbl[12];
  logic [4:0] keys[6];

  initial begin
    int wret, nw, nl;
    logic [15:0] ri;

    tbl[0]  = '{16'hD0FB, 3, 1, 0};
    tbl[1]  = '{16'hA148, 6, 1, 0};
    tbl[2]  = '{16'hA900, 5, 0, 1};
    tbl[3]  = '{16'hB865, 5, 1, 0};
    tbl[4]  = '{16'hC0F2, 5, 1, 0};
    tbl[5]  = '{16'hE000, 2, 0, 0};
    tbl[6]  = '{16'hB0E9, 6, 1, 0};
    tbl[7]  = '{16'h0000, 2, 0, 0};
    tbl[8]  = '{16'hC800, 2, 0, 0};
    tbl[9]  = '{16'hD87F, 2, 0, 0};
    tbl[10] = '{16'hD37F, 3, 1, 0};
    tbl[11] = '{16'hAD1B, 5, 0, 1};
    keys[0] = 5'b11010; keys[1] = 5'b11000; keys[2] = 5'b10100;
    keys[3] = 5'b10101; keys[4] = 5'b10110; keys[5] = 5'b10111;

    reset = 1'b1; s = 1'b0; instr = 16'hFFFF;
    tick();
    tick();
    chk("reset_hold", observe(), wait_vec(16'h0000));
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle_%0d", k), observe(), wait_vec(16'h0000));
    end

    // Table: B865 followed directly by C0F2 exercises the back-to-back handoff.
    for (int t = 0; t < 12; t++) begin
      run_instr(tbl[t].instr, wret, nw, nl);
      chk_int($sformatf("wret_%h", tbl[t].instr), wret, tbl[t].wret);
      chk_int($sformatf("nwrite_%h", tbl[t].instr), nw, tbl[t].nwrite);
      chk_int($sformatf("nloads_%h", tbl[t].instr), nl, tbl[t].nloads);
      if (t != 3) begin
        tick();
        chk($sformatf("gap_%h", tbl[t].instr), observe(), wait_vec(tbl[t].instr));
      end
    end

    // Reset in cycle 3 of an ADD aborts before EXEC/WRITE_REG.
    s = 1'b1; instr = 16'hA148;
    tick();
    s = 1'b0;
    tick();
    begin
      out_t e;
      e = wait_vec(16'hA148); e.w = 1'b0; e.readnum = 3'd1; e.loada = 1'b1;
      chk("abort_c2", observe(), e);
    end
    tick();
    reset = 1'b1;
    tick();
    chk("abort_c4", observe(), wait_vec(16'h0000));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_after_%0d", k), observe(), wait_vec(16'h0000));
    end

    // Reset beats a simultaneous start request.
    reset = 1'b1; s = 1'b1; instr = 16'hD0FB;
    tick();
    reset = 1'b0; s = 1'b0;
    chk("reset_vs_s", observe(), wait_vec(16'h0000));
    tick();
    chk("reset_vs_s_next", observe(), wait_vec(16'h0000));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7) < 6)
        ri = {keys[$urandom_range(5)], 11'($urandom)};
      else
        ri = 16'($urandom);
      run_instr(ri, wret, nw, nl);
      if ($urandom_range(1) == 0) begin
        tick();
        chk("rand_gap", observe(), wait_vec(ri));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
